// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low seven-segment drive and reconstructs the eight
// hex digits being displayed, with glitch filtering, error flags and a staleness timer.
module seg7_scan_decoder #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1048576
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [6:0]  out7,
    input  logic [7:0]  en_out,
    input  logic        clr_err,
    output logic [31:0] digits,
    output logic [7:0]  blank,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        err_seg,
    output logic        err_en,
    output logic        stale
);

    localparam int unsigned CNT_W = $clog2(SETTLE + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] SETTLE_MAX  = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] STAB_ONE    = CNT_W'(1);
    localparam logic [TO_W-1:0]  TIMEOUT_MAX = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_ONE      = TO_W'(1);

    typedef struct packed {
        logic       valid;
        logic       dark;
        logic [3:0] value;
    } seg_dec_t;

    function automatic seg_dec_t decode_seg(input logic [6:0] seg);
        seg_dec_t d;
        d.valid = 1'b1;
        d.dark  = 1'b0;
        d.value = 4'h0;
        case (seg)
            7'h40: d.value = 4'h0;
            7'h79: d.value = 4'h1;
            7'h24: d.value = 4'h2;
            7'h30: d.value = 4'h3;
            7'h19: d.value = 4'h4;
            7'h12: d.value = 4'h5;
            7'h02: d.value = 4'h6;
            7'h78: d.value = 4'h7;
            7'h00: d.value = 4'h8;
            7'h10: d.value = 4'h9;
            7'h08: d.value = 4'hA;
            7'h03: d.value = 4'hB;
            7'h46: d.value = 4'hC;
            7'h21: d.value = 4'hD;
            7'h06: d.value = 4'hE;
            7'h0E: d.value = 4'hF;
            7'h7F: d.dark  = 1'b1;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    logic [14:0]      samp_q;
    logic [14:0]      prev_q;
    logic [CNT_W-1:0] stab_q;
    logic             capture;

    logic [7:0]       en_low;
    seg_dec_t         dec;
    logic             one_low;
    logic             multi_low;
    logic [2:0]       dig_idx;
    logic             cap_ok;
    logic             set_seg;
    logic             set_en;

    logic [31:0]      work_digits;
    logic [7:0]       work_blank;
    logic [7:0]       seen_q;
    logic             frame_full;
    logic [TO_W-1:0]  to_q;

    // Input stage: one register of the raw drive, then a run-length counter on it.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            samp_q <= '0;
            prev_q <= '0;
            stab_q <= '0;
        end else begin
            samp_q <= {en_out, out7};
            prev_q <= samp_q;
            if (samp_q != prev_q) begin
                stab_q <= STAB_ONE;
            end else if (stab_q != SETTLE_MAX) begin
                stab_q <= stab_q + STAB_ONE;
            end
        end
    end

    // Fires only on the SETTLE-1 -> SETTLE step, so a long dwell captures once.
    assign capture = (samp_q == prev_q) && (stab_q == SETTLE_LAST);

    always_comb begin
        en_low    = ~samp_q[14:7];
        dec       = decode_seg(samp_q[6:0]);
        one_low   = (en_low != '0) && ((en_low & (en_low - 8'd1)) == '0);
        multi_low = (en_low != '0) && !one_low;
        dig_idx   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (en_low[i]) begin
                dig_idx = 3'(i);
            end
        end
        cap_ok  = capture && one_low && dec.valid;
        set_seg = capture && one_low && !dec.valid;
        set_en  = capture && multi_low;
    end

    assign frame_full = &seen_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            work_digits <= '0;
            work_blank  <= '0;
            seen_q      <= '0;
        end else begin
            if (cap_ok) begin
                work_digits[{dig_idx, 2'b00} +: 4] <= dec.value;
                work_blank[dig_idx]                <= dec.dark;
            end
            seen_q <= (frame_full ? 8'h00 : seen_q) | (cap_ok ? (8'd1 << dig_idx) : 8'h00);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            digits      <= '0;
            blank       <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= frame_full;
            if (frame_full) begin
                digits      <= work_digits;
                blank       <= work_blank;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Sticky flags: a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            err_seg <= 1'b0;
            err_en  <= 1'b0;
        end else begin
            if (set_seg) begin
                err_seg <= 1'b1;
            end else if (clr_err) begin
                err_seg <= 1'b0;
            end
            if (set_en) begin
                err_en <= 1'b1;
            end else if (clr_err) begin
                err_en <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            to_q <= '0;
        end else if (cap_ok) begin
            to_q <= '0;
        end else if (to_q != TIMEOUT_MAX) begin
            to_q <= to_q + TO_ONE;
        end
    end

    assign stale = (to_q == TIMEOUT_MAX);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised and directed bench for seg7_scan_decoder, checked every cycle against
// a run-length/table-lookup model of the display observer.
module tb_seg7_scan_decoder;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  out7 = 7'h7F;
    logic [7:0]  en_out = 8'hFF;
    logic        clr_err = 1'b0;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        err_seg;
    logic        err_en;
    logic        stale;

    seg7_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .Clk(clk), .Rst(rst), .out7(out7), .en_out(en_out), .clr_err(clr_err),
        .digits(digits), .blank(blank), .frame_done(frame_done),
        .frame_count(frame_count), .err_seg(err_seg), .err_en(err_en), .stale(stale)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;
    bit rand_clr = 1'b0;

    // Model state: visible outputs, working frame, and the sampled-input run tracker.
    logic [31:0] m_digits = '0, w_digits = '0;
    logic [7:0]  m_blank = '0, w_blank = '0, m_seen = '0;
    logic        m_done = 1'b0, m_eseg = 1'b0, m_een = 1'b0;
    logic [15:0] m_count = '0;
    int unsigned m_tcnt = 0;
    logic [14:0] last_x = '0, pend_x = '0;
    int unsigned run_len = 0;
    bit          pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin : model
        logic [7:0]  e;
        logic [6:0]  s;
        logic [14:0] x;
        int          lows, idx, val;
        bit          valid_cap, set_s, set_e;
        if (rst) begin
            m_digits = '0; m_blank = '0; m_done = 1'b0; m_count = '0;
            m_eseg = 1'b0; m_een = 1'b0; w_digits = '0; w_blank = '0; m_seen = '0;
            m_tcnt = 0; last_x = '0; run_len = 0; pend = 1'b0; pend_x = '0;
        end else begin
            m_done = 1'b0;
            if (m_seen == 8'hFF) begin
                m_digits = w_digits;
                m_blank  = w_blank;
                m_done   = 1'b1;
                m_count  = m_count + 16'd1;
                m_seen   = '0;
            end
            valid_cap = 1'b0; set_s = 1'b0; set_e = 1'b0;
            if (pend) begin
                e = pend_x[14:7];
                s = pend_x[6:0];
                lows = $countones(~e);
                if (lows == 1) begin
                    idx = 0;
                    for (int i = 0; i < 8; i++) if (!e[i]) idx = i;
                    val = -1;
                    for (int k = 0; k < 16; k++) if (seg_tab[k] == s) val = k;
                    if (val >= 0) begin
                        w_digits[idx*4 +: 4] = 4'(val);
                        w_blank[idx] = 1'b0;
                        valid_cap = 1'b1;
                    end else if (s == 7'h7F) begin
                        w_digits[idx*4 +: 4] = 4'h0;
                        w_blank[idx] = 1'b1;
                        valid_cap = 1'b1;
                    end else begin
                        set_s = 1'b1;
                    end
                    if (valid_cap) m_seen[idx] = 1'b1;
                end else if (lows > 1) begin
                    set_e = 1'b1;
                end
            end
            if (valid_cap) m_tcnt = 0;
            else if (m_tcnt < TIMEOUT) m_tcnt++;
            m_eseg = set_s ? 1'b1 : (clr_err ? 1'b0 : m_eseg);
            m_een  = set_e ? 1'b1 : (clr_err ? 1'b0 : m_een);
            x = {en_out, out7};
            if (x == last_x) begin
                if (run_len <= SETTLE) run_len++;
            end else begin
                run_len = 1;
            end
            last_x = x;
            pend   = (run_len == SETTLE);
            pend_x = x;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("digits", digits, m_digits);
            check("blank", 32'(blank), 32'(m_blank));
            check("frame_done", 32'(frame_done), 32'(m_done));
            check("frame_count", 32'(frame_count), 32'(m_count));
            check("err_seg", 32'(err_seg), 32'(m_eseg));
            check("err_en", 32'(err_en), 32'(m_een));
            check("stale", 32'(stale), 32'(m_tcnt == TIMEOUT));
        end
    end

    task automatic drive(input logic [7:0] en, input logic [6:0] seg, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            en_out  = en;
            out7    = seg;
            clr_err = rand_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
        end
    endtask

    task automatic show(input int idx, input int val, input int n);
        drive(~(8'(1) << idx), seg_tab[val], n);
    endtask

    task automatic scan_word(input logic [31:0] w, input bit glitch);
        logic [6:0] sg;
        for (int i = 0; i < 8; i++) begin
            sg = seg_tab[w[i*4 +: 4]];
            if (glitch) begin
                drive(~(8'(1) << i), sg ^ 7'h01, 1);
                drive(~(8'(1) << i), sg ^ 7'h02, 1);
                drive(~(8'(1) << i), sg, 14);
            end else begin
                drive(~(8'(1) << i), sg, 16);
            end
            drive(8'hFF, 7'h7F, 2);
        end
    endtask

    initial begin : stim
        int r, dw, idx, seq;
        repeat (3) @(negedge clk);
        check("rst_digits", digits, 32'h0);
        check("rst_count", 32'(frame_count), 32'h0);
        check("rst_flags", 32'({frame_done, err_seg, err_en, stale, blank}), 32'h0);
        rst = 1'b0;
        checking = 1'b1;
        drive(8'hFF, 7'h7F, 4);

        scan_word(32'h76543210, 1'b0);
        drive(8'hFF, 7'h7F, 4);
        check("t1_digits", digits, 32'h76543210);
        check("t1_model_digits", m_digits, 32'h76543210);
        check("t1_blank", 32'(blank), 32'h0);
        check("t1_count", 32'(frame_count), 32'd1);
        check("t1_errs", 32'({err_seg, err_en}), 32'h0);

        scan_word(32'h76543210, 1'b1);
        drive(8'hFF, 7'h7F, 4);
        check("t2_digits", digits, 32'h76543210);
        check("t2_count", 32'(frame_count), 32'd2);
        check("t2_err_seg", 32'(err_seg), 32'h0);

        for (int i = 0; i < 8; i++) begin
            if (i == 3)      drive(~(8'(1) << i), 7'h7F, 16);
            else if (i == 5) drive(~(8'(1) << i), 7'h0E, 16);
            else             drive(~(8'(1) << i), 7'h00, 16);
            drive(8'hFF, 7'h7F, 2);
        end
        drive(8'hFF, 7'h7F, 4);
        check("t3_digits", digits, 32'h88F80888);
        check("t3_blank", 32'(blank), 32'h08);
        check("t3_model_blank", 32'(m_blank), 32'h08);
        check("t3_count", 32'(frame_count), 32'd3);

        drive(8'hFB, 7'h55, 8);
        drive(8'hFC, 7'h00, 8);
        drive(8'hFF, 7'h7F, 4);
        check("t4_err_seg", 32'(err_seg), 32'h1);
        check("t4_err_en", 32'(err_en), 32'h1);
        check("t4_count", 32'(frame_count), 32'd3);
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        check("t4_clr", 32'({err_seg, err_en}), 32'h0);

        show(0, 5, 16);
        drive(8'hFF, 7'h7F, 40);
        check("t5_not_stale", 32'(stale), 32'h0);
        drive(8'hFF, 7'h7F, 30);
        check("t5_stale", 32'(stale), 32'h1);
        show(1, 3, 16);
        check("t5_stale_clear", 32'(stale), 32'h0);

        rand_clr = 1'b1;
        seq = 0;
        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 99));
            dw = int'($urandom_range(1, 9));
            idx = (r % 2 == 0) ? seq : int'($urandom_range(0, 7));
            if (r < 60) begin
                if ($urandom_range(0, 9) == 0) drive(~(8'(1) << idx), 7'h7F, dw);
                else show(idx, int'($urandom_range(0, 15)), dw);
                seq = (seq + 1) % 8;
            end else if (r < 70) begin
                drive(~(8'(1) << idx), 7'($urandom), dw);
            end else if (r < 78) begin
                drive(8'($urandom), seg_tab[$urandom_range(0, 15)], dw);
            end else begin
                drive(8'hFF, 7'h7F, dw);
            end
        end
        rand_clr = 1'b0;
        drive(8'hFF, 7'h7F, 4);

        for (int i = 0; i < 5; i++) show(i, i + 1, 16);
        #2 rst = 1'b1;
        #1;
        check("t6_async_digits", digits, 32'h0);
        check("t6_async_count", 32'(frame_count), 32'h0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        drive(8'hFF, 7'h7F, 4);
        scan_word(32'h99999999, 1'b0);
        drive(8'hFF, 7'h7F, 4);
        check("t6_digits", digits, 32'h99999999);
        check("t6_count", 32'(frame_count), 32'd1);
        check("t6_blank", 32'(blank), 32'h0);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
